fxp_div_seq: RTL and testbench



---
 rtl/fxp_div_pkg.sv | 17 +
 rtl/fxp_div_step.sv | 29 ++
 rtl/fxp_div_seq.sv | 173 +++++++++++++++++
 tb/tb_fxp_div_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_div_pkg.sv
// Shared constants and types for the sequential Q8.24 fixed-point divider.
package fxp_div_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 24;
    localparam int CNT_W     = $clog2(WIDTH_DEF + 2);

    localparam logic [WIDTH_DEF-1:0] Q_ONE = WIDTH_DEF'(1) << FRAC_DEF;
    localparam logic [WIDTH_DEF-1:0] Q_SAT = {WIDTH_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module fxp_div_step
    import fxp_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   r,
    input  logic             feed,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] d_ext_s;

    // Compare uses the full WIDTH+1 remainder so the shifted value never overflows.
    always_comb begin
        shifted_s = {r[WIDTH-1:0], feed};
        d_ext_s   = {1'b0, d};
        qbit      = (shifted_s >= d_ext_s);
        if (qbit) begin
            r_next = shifted_s - d_ext_s;
        end else begin
            r_next = shifted_s;
        end
    end

endmodule

// File: rtl/fxp_div_seq.sv
// Sequential unsigned Q8.24 restoring divider, q = floor(n * 2^FRAC / d), one bit per clock.
// Define FXP_DIV_ROUND_EN for one extra guard iteration and round-half-up of the quotient.
module fxp_div_seq
    import fxp_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             sat
);

    localparam int IW = WIDTH - FRAC;
    localparam int CW = $clog2(WIDTH + 2);
`ifdef FXP_DIV_ROUND_EN
    localparam int ITERS = WIDTH + 1;
`else
    localparam int ITERS = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH:0]   rem_nxt_s;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] feed_r;
    logic [ITERS-1:0] quot_r;
    logic [ITERS-1:0] quot_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic             qbit_s;
    logic             accept_s;
    logic             release_s;
    logic             sat_in_s;
    logic             last_s;
    logic [WIDTH-1:0] res_q_s;
    logic             res_sat_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] q_r;
    logic             sat_r;

    fxp_div_step #(.WIDTH(WIDTH)) u_step (
        .r      (rem_r),
        .feed   (feed_r[WIDTH-1]),
        .d      (d_r),
        .r_next (rem_nxt_s),
        .qbit   (qbit_s)
    );

    assign accept_s   = in_valid && in_ready_r;
    assign release_s  = out_valid_r && out_ready;
    assign last_s     = (cnt_r == LAST);
    assign quot_nxt_s = {quot_r[ITERS-2:0], qbit_s};

    // A quotient of 2^WIDTH or more is impossible to represent, so it is caught before iterating.
    assign sat_in_s = (d == {WIDTH{1'b0}}) || ((n >> IW) >= d);

`ifdef FXP_DIV_ROUND_EN
    logic [WIDTH:0] rounded_s;

    // Add the guard bit to the truncated quotient; a carry out means the result wrapped.
    always_comb begin
        rounded_s = {1'b0, quot_nxt_s[ITERS-1:1]} + (WIDTH+1)'(quot_nxt_s[0]);
        res_sat_s = rounded_s[WIDTH];
        if (rounded_s[WIDTH]) begin
            res_q_s = {WIDTH{1'b1}};
        end else begin
            res_q_s = rounded_s[WIDTH-1:0];
        end
    end
`else
    // Truncating build: the collected quotient bits are the result.
    always_comb begin
        res_q_s   = quot_nxt_s;
        res_sat_s = 1'b0;
    end
`endif

    // Next-state logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = sat_in_s ? DONE : RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (release_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rem_r       <= '0;
            d_r         <= '0;
            feed_r      <= '0;
            quot_r      <= '0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            q_r         <= '0;
            sat_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        d_r    <= d;
                        rem_r  <= (WIDTH+1)'(n >> IW);
                        feed_r <= n << FRAC;
                        quot_r <= '0;
                        cnt_r  <= '0;
                        if (sat_in_s) begin
                            q_r   <= {WIDTH{1'b1}};
                            sat_r <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rem_r  <= rem_nxt_s;
                    feed_r <= feed_r << 1;
                    quot_r <= quot_nxt_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (last_s) begin
                        q_r   <= res_q_s;
                        sat_r <= res_sat_s;
                    end
                end
                DONE: begin
                    // out_valid rises one cycle after entering DONE and drops on the handshake.
                    out_valid_r <= !release_s;
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign q         = q_r;
    assign sat       = sat_r;

endmodule

// File: tb/tb_fxp_div_seq.sv
// Self-checking bench for fxp_div_seq: directed spec vectors plus randomized ops against an arithmetic model.
module tb_fxp_div_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] n;
    logic [31:0] d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] q;
    logic        sat;

    int n_vec;
    int n_bad;

`ifdef FXP_DIV_ROUND_EN
    localparam int LAT = 34;
`else
    localparam int LAT = 33;
`endif

    fxp_div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact quotient of n*2^24 by d with wide integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eq, output logic es);
        logic [63:0] num;
        logic [63:0] qq;
        if (b == 32'd0 || (a >> 8) >= b) begin
            eq = 32'hFFFF_FFFF;
            es = 1'b1;
        end else begin
`ifdef FXP_DIV_ROUND_EN
            num = {7'd0, a, 25'd0};
            qq  = num / {32'd0, b};
            qq  = (qq >> 1) + (qq & 64'd1);
`else
            num = {8'd0, a, 24'd0};
            qq  = num / {32'd0, b};
`endif
            if (qq > 64'h0000_0000_FFFF_FFFF) begin
                eq = 32'hFFFF_FFFF;
                es = 1'b1;
            end else begin
                eq = qq[31:0];
                es = 1'b0;
            end
        end
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                         output int lat, output logic [31:0] qo, output logic so);
        @(negedge clk);
        n = a;
        d = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        qo = q;
        so = sat;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 32'd0 || sat !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b q=%h sat=%b, want 1 0 00000000 0",
                     in_ready, out_valid, q, sat);
        end
    endtask

    task automatic test_directed();
        logic [31:0] tn [7];
        logic [31:0] td [7];
        logic [31:0] tq [7];
        logic        ts [7];
        int          lat;
        logic [31:0] qo;
        logic        so;
        int          elat;
        tn[0] = 32'h0300_0000; td[0] = 32'h0180_0000; tq[0] = 32'h0200_0000; ts[0] = 1'b0;
        tn[1] = 32'h0100_0000; td[1] = 32'h0019_999A; tq[1] = 32'h09FF_FFD8; ts[1] = 1'b0;
`ifdef FXP_DIV_ROUND_EN
        tn[2] = 32'h0200_0000; td[2] = 32'h0300_0000; tq[2] = 32'h00AA_AAAB; ts[2] = 1'b0;
`else
        tn[2] = 32'h0200_0000; td[2] = 32'h0300_0000; tq[2] = 32'h00AA_AAAA; ts[2] = 1'b0;
`endif
        tn[3] = 32'h0100_0000; td[3] = 32'h0000_0000; tq[3] = 32'hFFFF_FFFF; ts[3] = 1'b1;
        tn[4] = 32'h8000_0000; td[4] = 32'h0040_0000; tq[4] = 32'hFFFF_FFFF; ts[4] = 1'b1;
        tn[5] = 32'h0001_0000; td[5] = 32'h0000_0100; tq[5] = 32'hFFFF_FFFF; ts[5] = 1'b1;
        tn[6] = 32'h0000_FF00; td[6] = 32'h0000_0100; tq[6] = 32'hFF00_0000; ts[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            do_op(tn[i], td[i], 0, lat, qo, so);
            elat = ts[i] ? 1 : LAT;
            n_vec++;
            if (qo !== tq[i] || so !== ts[i]) begin
                n_bad++;
                $display("FAIL directed_%0d: n=%h d=%h got q=%h sat=%b, want q=%h sat=%b",
                         i, tn[i], td[i], qo, so, tq[i], ts[i]);
            end
            n_vec++;
            if (lat != elat) begin
                n_bad++;
                $display("FAIL latency_%0d: got %0d cycles, want %0d", i, lat, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q0;
        logic        s0;
        int          lat;
        logic [31:0] qo;
        logic        so;
        logic [31:0] eq;
        logic        es;
        bit          bad;
        @(negedge clk);
        n = 32'h0300_0000;
        d = 32'h0180_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q0 = q;
        s0 = sat;
        bad = (out_valid !== 1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                @(negedge clk);
                n = 32'h0500_0000;
                d = 32'h0100_0000;
                in_valid = 1'b1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== q0 || sat !== s0) bad = 1'b1;
        end
        n_vec++;
        if (bad || q0 !== 32'h0200_0000 || s0 !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold: q=%h sat=%b out_valid=%b in_ready=%b, want q=02000000 sat=0 held 1/0",
                     q, sat, out_valid, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: got out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 32'h0700_0000 : 32'h0012_3456;
            d = (k == 0) ? 32'h0200_0000 : 32'h0000_ABCD;
            model(n, d, eq, es);
            do_op(n, d, 0, lat, qo, so);
            n_vec++;
            if (qo !== eq || so !== es || lat < 1) begin
                n_bad++;
                $display("FAIL back_to_back_%0d: got q=%h sat=%b lat=%0d, want q=%h sat=%b",
                         k, qo, so, lat, eq, es);
            end
        end
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [31:0] qo;
        logic        so;
        logic [31:0] eq;
        logic        es;
        bit          stale;
        @(negedge clk);
        n = 32'h0300_0000;
        d = 32'h0180_0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 32'd0 || sat !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: got in_ready=%b out_valid=%b q=%h sat=%b, want 1 0 00000000 0",
                     in_ready, out_valid, q, sat);
        end
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_vec++;
        if (stale) begin
            n_bad++;
            $display("FAIL reset_stale: got out_valid=1 after reset, want 0");
        end
        model(32'h0200_0000, 32'h0300_0000, eq, es);
        do_op(32'h0200_0000, 32'h0300_0000, 0, lat, qo, so);
        n_vec++;
        if (qo !== eq || so !== es || lat != LAT) begin
            n_bad++;
            $display("FAIL reset_next_op: got q=%h sat=%b lat=%0d, want q=%h sat=%b lat=%0d",
                     qo, so, lat, eq, es, LAT);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic        es;
        logic [31:0] qo;
        logic        so;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(32'h0100_0000, 1);
                2: b = 32'($urandom_range(511, 0));
                default: b = a >> $urandom_range(12, 6);
            endcase
            model(a, b, eq, es);
            do_op(a, b, $urandom_range(3, 0), lat, qo, so);
            n_vec++;
            if (qo !== eq || so !== es) begin
                n_bad++;
                $display("FAIL random_%0d: n=%h d=%h got q=%h sat=%b, want q=%h sat=%b",
                         i, a, b, qo, so, eq, es);
            end
            n_vec++;
            if (lat != (es ? 1 : LAT)) begin
                n_bad++;
                $display("FAIL random_lat_%0d: got %0d cycles, want %0d", i, lat, es ? 1 : LAT);
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n         = 32'd0;
        d         = 32'd0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
